bram_fifo_ctrl: RTL and testbench



---
 rtl/bram_fifo_ctrl.sv | 105 ++++++++++
 tb/tb_bram_fifo_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO controller over a 1-cycle-latency BRAM with a 2-entry output buffer
module bram_fifo_ctrl #(
  parameter int width     = 4,
  parameter int depth     = 1024,
  parameter int addrWidth = $clog2(depth)
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   enq__ENA,
  input  logic [width-1:0]       enq_v,
  output logic                   enq__RDY,
  input  logic                   deq__ENA,
  output logic                   deq__RDY,
  output logic [width-1:0]       first,
  output logic                   first__RDY,
  output logic [addrWidth+1:0]   count,
  output logic                   bram_write__ENA,
  output logic [addrWidth-1:0]   bram_write_addr,
  output logic [width-1:0]       bram_write_data,
  output logic                   bram_read__ENA,
  output logic [addrWidth-1:0]   bram_read_addr,
  input  logic [width-1:0]       bram_dataOut,
  input  logic                   bram_dataOut__RDY
);

  localparam logic [addrWidth:0] full_level = (addrWidth+1)'(depth);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [addrWidth:0] wr_ptr;
  logic [addrWidth:0] rd_ptr;
  logic [addrWidth:0] bcnt;
  logic               primed;
  logic               inflight;
  logic [1:0]         out_cnt;
  logic [1:0]         cnt_after_pop;
  logic [width-1:0]   slot0;
  logic [width-1:0]   slot1;
  logic [2:0]         occ_next;
  logic               enq_fire;
  logic               deq_fire;
  logic               rd_issue;
  logic               capture;

  assign bcnt       = wr_ptr - rd_ptr;
  assign enq__RDY   = primed && (bcnt != full_level);
  assign deq__RDY   = (out_cnt != 2'd0);
  assign first__RDY = (out_cnt != 2'd0);
  assign first      = slot0;

  // Strobes that arrive while not ready are dropped rather than corrupting state.
  assign enq_fire = enq__ENA && enq__RDY;
  assign deq_fire = deq__ENA && deq__RDY;

  // Issue a read only if the returning word is guaranteed a free output slot.
  assign occ_next = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, deq_fire};
  assign rd_issue = (bcnt != '0) && (occ_next < 3'd2);

  // Only accept returning data for a read this controller issued since reset.
  assign capture       = bram_dataOut__RDY && inflight;
  assign cnt_after_pop = out_cnt - {1'b0, deq_fire};

  assign bram_write__ENA = enq_fire;
  assign bram_write_addr = wr_ptr[addrWidth-1:0];
  assign bram_write_data = enq_v;
  assign bram_read__ENA  = rd_issue;
  assign bram_read_addr  = rd_ptr[addrWidth-1:0];

  assign count = {1'b0, bcnt} + {{(addrWidth+1){1'b0}}, inflight} + {{addrWidth{1'b0}}, out_cnt};

  // Pointer, in-flight and priming state.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      primed   <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;
      inflight <= rd_issue;
      primed   <= 1'b1;
    end
  end

  // Output buffer: pop the head first, then append the captured word behind what remains.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_cnt <= 2'd0;
      slot0   <= '0;
      slot1   <= '0;
    end else begin
      if (deq_fire) slot0 <= slot1;
      if (capture) begin
        if (cnt_after_pop == 2'd0) slot0 <= bram_dataOut;
        else                       slot1 <= bram_dataOut;
      end
      out_cnt <= cnt_after_pop + {1'b0, capture};
    end
  end

  // Flag protocol violations by the datapath.
  assert property (@(posedge CLK) disable iff (!nRST) enq__ENA |-> enq__RDY);
  assert property (@(posedge CLK) disable iff (!nRST) deq__ENA |-> deq__RDY);

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - self-checking bench for bram_fifo_ctrl with a behavioural BRAM and queue model
module tb_bram_fifo_ctrl;

  localparam int W  = 4;
  localparam int D  = 8;
  localparam int AW = 3;

  logic          CLK;
  logic          nRST;
  logic          enq_ena;
  logic [W-1:0]  enq_v;
  logic          enq_rdy;
  logic          deq_ena;
  logic          deq_rdy;
  logic [W-1:0]  first;
  logic          first_rdy;
  logic [AW+1:0] count;
  logic          bram_wena;
  logic [AW-1:0] bram_waddr;
  logic [W-1:0]  bram_wdata;
  logic          bram_rena;
  logic [AW-1:0] bram_raddr;
  logic [W-1:0]  bram_dout;
  logic          bram_drdy = 1'b0;

  bram_fifo_ctrl #(.width(W), .depth(D)) dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .enq__ENA         (enq_ena),
    .enq_v            (enq_v),
    .enq__RDY         (enq_rdy),
    .deq__ENA         (deq_ena),
    .deq__RDY         (deq_rdy),
    .first            (first),
    .first__RDY       (first_rdy),
    .count            (count),
    .bram_write__ENA  (bram_wena),
    .bram_write_addr  (bram_waddr),
    .bram_write_data  (bram_wdata),
    .bram_read__ENA   (bram_rena),
    .bram_read_addr   (bram_raddr),
    .bram_dataOut     (bram_dout),
    .bram_dataOut__RDY(bram_drdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // BRAM with registered read; not reset so a stale return can arrive across a reset.
  logic [W-1:0] mem [D];
  always @(posedge CLK) begin
    if (bram_wena) mem[bram_waddr] <= bram_wdata;
    if (bram_rena) bram_dout <= mem[bram_raddr];
    bram_drdy <= bram_rena;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: stored region, one optional word in flight, and a visible output queue.
  int bq[$];
  int ob[$];
  int fly   = 0;
  int fly_v = 0;
  bit m_primed = 1'b0;
  bit mchk = 1'b0;

  function automatic bit m_enq_rdy();
    return m_primed && (bq.size() != D);
  endfunction

  function automatic bit m_rd(input bit deq);
    return (bq.size() != 0) && ((ob.size() + fly - int'(deq)) < 2);
  endfunction

  function automatic int m_count();
    return bq.size() + ob.size() + fly;
  endfunction

  task automatic step();
    bit do_rd;
    #1;
    if (mchk) begin
      chk("m_enq_rdy", enq_rdy, m_enq_rdy());
      chk("m_deq_rdy", deq_rdy, ob.size() != 0);
      chk("m_first_rdy", first_rdy, ob.size() != 0);
      if (ob.size() != 0) chk("m_first", first, ob[0]);
      chk("m_count", count, m_count());
      chk("m_rd_ena", bram_rena, m_rd(deq_ena));
    end
    do_rd = m_rd(deq_ena);
    @(posedge CLK);
    if (!nRST) begin
      bq.delete();
      ob.delete();
      fly = 0;
      m_primed = 1'b0;
    end else begin
      m_primed = 1'b1;
      if (deq_ena && ob.size() != 0) void'(ob.pop_front());
      if (fly != 0) ob.push_back(fly_v);
      if (do_rd) begin
        fly   = 1;
        fly_v = bq.pop_front();
      end else begin
        fly = 0;
      end
      if (enq_ena) bq.push_back(int'(enq_v));
    end
    @(negedge CLK);
  endtask

  typedef struct {
    bit           nrst;
    bit           enq;
    logic [W-1:0] v;
    bit           deq;
    bit           e_enq_rdy;
    bit           e_deq_rdy;
    logic [W-1:0] e_first;
    int           e_count;
    bit           e_rd;
  } vec_t;

  vec_t tv [8];
  int   popped[$];
  int   sent;
  int   first_pop;
  int   last_pop;
  int   max_cnt;
  int   cyc;

  initial begin
    tv[0] = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0};
    tv[1] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b0};
    tv[3] = '{1'b1, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b0};
    tv[4] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1, 1'b1};
    tv[5] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1, 1'b0};
    tv[6] = '{1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 4'hA, 1, 1'b0};
    tv[7] = '{1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b0};

    nRST = 1'b0; enq_ena = 1'b0; enq_v = '0; deq_ena = 1'b0;
    @(negedge CLK);
    step();
    mchk = 1'b1;

    // Priming and single-entry latency.
    for (int i = 0; i < 8; i++) begin
      nRST = tv[i].nrst; enq_ena = tv[i].enq; enq_v = tv[i].v; deq_ena = tv[i].deq;
      #1;
      chk($sformatf("tv%0d_enq_rdy", i), enq_rdy, tv[i].e_enq_rdy);
      chk($sformatf("tv%0d_deq_rdy", i), deq_rdy, tv[i].e_deq_rdy);
      if (tv[i].e_deq_rdy) chk($sformatf("tv%0d_first", i), first, tv[i].e_first);
      chk($sformatf("tv%0d_count", i), count, tv[i].e_count);
      chk($sformatf("tv%0d_rd_ena", i), bram_rena, tv[i].e_rd);
      step();
    end
    enq_ena = 1'b0; deq_ena = 1'b0;

    // Full: ten entries with no dequeue.
    sent = 0;
    for (int i = 0; i < 40 && sent < 10; i++) begin
      enq_ena = m_enq_rdy();
      enq_v   = W'(sent + 3);
      if (enq_ena) sent++;
      step();
    end
    enq_ena = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("full_sent", sent, 10);
    chk("full_count", count, 10);
    chk("full_enq_rdy", enq_rdy, 0);
    deq_ena = 1'b1;
    #1;
    chk("full_deq_rd_issue", bram_rena, 1);
    chk("full_deq_enq_rdy", enq_rdy, 0);
    step();
    deq_ena = 1'b0;
    #1;
    chk("full_reopen_enq_rdy", enq_rdy, 1);
    chk("full_reopen_count", count, 9);
    step();

    // Drain.
    for (int i = 0; i < 60 && m_count() > 0; i++) begin
      deq_ena = (ob.size() != 0);
      step();
    end
    deq_ena = 1'b0;
    step();
    chk("drain_count", count, 0);

    // Streaming 0..15 with dequeue whenever possible.
    sent = 0; popped.delete(); max_cnt = 0; cyc = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 80 && popped.size() < 16; i++) begin
      enq_ena = (sent < 16) && m_enq_rdy();
      enq_v   = W'(sent);
      deq_ena = (ob.size() != 0);
      #1;
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (deq_ena) begin
        popped.push_back(int'(first));
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (enq_ena) sent++;
      step();
      cyc++;
    end
    enq_ena = 1'b0; deq_ena = 1'b0;
    chk("stream_pops", popped.size(), 16);
    for (int i = 0; i < popped.size(); i++) chk($sformatf("stream_order%0d", i), popped[i], i);
    chk("stream_no_gap", last_pop - first_pop, 15);
    chk("stream_count_over_10", int'(max_cnt > 10), 0);

    // Pointer wrap with a constant occupancy of three.
    for (int i = 0; i < 3; i++) begin
      enq_ena = 1'b1; enq_v = W'($urandom_range(0, 15));
      step();
    end
    enq_ena = 1'b0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 20; i++) begin
      enq_ena = m_enq_rdy(); enq_v = W'($urandom_range(0, 15));
      deq_ena = (ob.size() != 0);
      #1;
      chk($sformatf("wrap_count%0d", i), count, 3);
      step();
    end
    enq_ena = 1'b0; deq_ena = 1'b0;

    // Reset mid-stream with a read in flight.
    for (int i = 0; i < 60 && m_count() > 0; i++) begin
      deq_ena = (ob.size() != 0);
      step();
    end
    deq_ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      enq_ena = 1'b1; enq_v = W'(i + 8);
      step();
    end
    enq_ena = 1'b0;
    for (int i = 0; i < 4; i++) step();
    enq_ena = 1'b1; enq_v = 4'hE; deq_ena = 1'b1;
    step();
    enq_ena = 1'b0; deq_ena = 1'b0; nRST = 1'b0;
    #1;
    chk("rst_pre_count", count, 5);
    step();
    nRST = 1'b1;
    #1;
    chk("rst_enq_rdy", enq_rdy, 0);
    chk("rst_deq_rdy", deq_rdy, 0);
    chk("rst_count", count, 0);
    chk("rst_rd_ena", bram_rena, 0);
    chk("rst_wr_ena", bram_wena, 0);
    step();
    #1;
    chk("rst_primed_enq_rdy", enq_rdy, 1);
    chk("rst_primed_count", count, 0);
    enq_ena = 1'b1; enq_v = 4'h3;
    step();
    enq_ena = 1'b0;
    step(); step();
    #1;
    chk("rst_after_deq_rdy", deq_rdy, 1);
    chk("rst_after_first", first, 3);
    step();

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      nRST = ($urandom_range(0, 199) != 0);
      enq_ena = nRST && m_enq_rdy() && ($urandom_range(0, 99) < 60);
      enq_v   = W'($urandom_range(0, 15));
      deq_ena = nRST && (ob.size() != 0) && ($urandom_range(0, 99) < 55);
      step();
    end
    nRST = 1'b1; enq_ena = 1'b0; deq_ena = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
